// File: rtl/ucsbece154_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ucsbece154_mem_arbiter
// Brief    : Shares the single SDRAM block-read port between the icache and
//            dcache refill paths. Grants one requester, issues a one-cycle
//            block-aligned read request, counts BLOCK_WORDS returned beats
//            and steers each beat strobe only to the granted cache.
// Options  : MEM_ARB_DPRIO_EN defined   -> fixed priority, dcache wins ties
//            MEM_ARB_DPRIO_EN undefined -> round-robin on ties (default)
// Revision : 1.0 - initial release
// ============================================================================
module ucsbece154_mem_arbiter #(
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              I_ReadRequest,
  input  logic [ADDR_W-1:0] I_ReadAddress,
  output logic [31:0]       I_DataIn,
  output logic              I_DataReady,

  input  logic              D_ReadRequest,
  input  logic [ADDR_W-1:0] D_ReadAddress,
  output logic [31:0]       D_DataIn,
  output logic              D_DataReady,

  output logic              SDRAM_ReadRequest,
  output logic [ADDR_W-1:0] SDRAM_ReadAddress,
  input  logic [31:0]       SDRAM_DataIn,
  input  logic              SDRAM_DataReady,

  output logic              Busy,
  output logic              GrantD
);

  localparam int CNT_W = $clog2(BLOCK_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              grant_q, grant_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic              any_req;
  logic              win_dcache;

  assign any_req = I_ReadRequest | D_ReadRequest;

`ifdef MEM_ARB_DPRIO_EN
  // Fixed priority: the dcache wins whenever it is requesting.
  assign win_dcache = D_ReadRequest;
`else
  // Round-robin pointer: 1 means the dcache is favoured on the next tie.
  logic rr_q, rr_d;

  // On a tie the pointer decides; a lone request always wins.
  assign win_dcache = (I_ReadRequest & D_ReadRequest) ? rr_q : D_ReadRequest;

  // Pointer moves to favour the requester that was not just granted.
  always_comb begin
    rr_d = rr_q;
    if ((state_q == S_IDLE) && any_req) begin
      rr_d = ~win_dcache;
    end
  end

  // Round-robin pointer register; reset favours the icache.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Next-state logic: grant and latch in IDLE, one-cycle ISSUE, count beats in BURST.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          grant_d = win_dcache;
          addr_d  = (win_dcache ? D_ReadAddress : I_ReadAddress) & ALIGN_MASK;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_BURST;
      end
      S_BURST: begin
        // Beats are consumed regardless of the requester's current level.
        if (SDRAM_DataReady) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, beat counter, owner and burst address registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
    end
  end

  // Strobes are only live in BURST, so stray beats in IDLE/ISSUE never leak.
  assign I_DataReady       = SDRAM_DataReady & (state_q == S_BURST) & ~grant_q;
  assign D_DataReady       = SDRAM_DataReady & (state_q == S_BURST) &  grant_q;
  assign I_DataIn          = SDRAM_DataIn;
  assign D_DataIn          = SDRAM_DataIn;
  assign SDRAM_ReadRequest = (state_q == S_ISSUE);
  assign SDRAM_ReadAddress = addr_q;
  assign Busy              = (state_q != S_IDLE);
  assign GrantD            = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ucsbece154_mem_arbiter
// Brief    : Scoreboard bench for ucsbece154_mem_arbiter. Expected requests
//            and beats are queued as stimulus is driven and popped by a
//            negedge monitor when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ucsbece154_mem_arbiter;

  localparam int BW = 4;

  logic        clk;
  logic        reset;
  logic        I_ReadRequest, D_ReadRequest;
  logic [31:0] I_ReadAddress, D_ReadAddress;
  logic [31:0] I_DataIn, D_DataIn;
  logic        I_DataReady, D_DataReady;
  logic        SDRAM_ReadRequest;
  logic [31:0] SDRAM_ReadAddress;
  logic [31:0] SDRAM_DataIn;
  logic        SDRAM_DataReady;
  logic        Busy, GrantD;

  ucsbece154_mem_arbiter #(.BLOCK_WORDS(BW), .ADDR_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .I_ReadRequest     (I_ReadRequest),
    .I_ReadAddress     (I_ReadAddress),
    .I_DataIn          (I_DataIn),
    .I_DataReady       (I_DataReady),
    .D_ReadRequest     (D_ReadRequest),
    .D_ReadAddress     (D_ReadAddress),
    .D_DataIn          (D_DataIn),
    .D_DataReady       (D_DataReady),
    .SDRAM_ReadRequest (SDRAM_ReadRequest),
    .SDRAM_ReadAddress (SDRAM_ReadAddress),
    .SDRAM_DataIn      (SDRAM_DataIn),
    .SDRAM_DataReady   (SDRAM_DataReady),
    .Busy              (Busy),
    .GrantD            (GrantD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        d;
    logic [31:0] v;
  } exp_t;

  exp_t req_q[$];
  exp_t beat_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   strobes = 0;
  bit   fav_d   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Winner as the arbitration rules describe it, independent of the DUT.
  function automatic bit predict();
`ifdef MEM_ARB_DPRIO_EN
    return D_ReadRequest;
`else
    if (I_ReadRequest && D_ReadRequest) return fav_d;
    return D_ReadRequest;
`endif
  endfunction

  // Monitor: pop and compare whenever the DUT issues a request or a strobe.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (SDRAM_ReadRequest) begin
        if (req_q.size() == 0) check("req_unexpected", 1, 0);
        else begin
          e = req_q.pop_front();
          check("req_grant", GrantD, e.d);
          check("req_addr", SDRAM_ReadAddress, e.v);
        end
      end
      if (I_DataReady || D_DataReady) begin
        strobes++;
        if (beat_q.size() == 0) check("beat_unexpected", {I_DataReady, D_DataReady}, 0);
        else begin
          e = beat_q.pop_front();
          check("beat_owner", {30'd0, I_DataReady, D_DataReady}, e.d ? 32'd1 : 32'd2);
          check("beat_data", e.d ? D_DataIn : I_DataIn, e.v);
        end
      end
    end
  end

  // Raise requests in cycle t and confirm no request is issued in t itself.
  task automatic raise(input bit ri, input bit rd);
    @(posedge clk); #1;
    if (ri) I_ReadRequest = 1'b1;
    if (rd) D_ReadRequest = 1'b1;
    @(negedge clk);
    check("issue_early", SDRAM_ReadRequest, 0);
  endtask

  task automatic drop(input bit d);
    if (d) D_ReadRequest = 1'b0;
    else   I_ReadRequest = 1'b0;
  endtask

  // One arbitrated burst; returns at the negedge of the cycle after the last beat.
  task automatic run_burst(input bit hold, input bit stray_issue, input int abort_after);
    bit          w;
    bit          got;
    int          k;
    logic [31:0] data;
    w = predict();
    fav_d = ~w;
    req_q.push_back('{d: w, v: (w ? D_ReadAddress : I_ReadAddress) & 32'hFFFF_FFF0});
    got = 1'b0;
    k = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (SDRAM_ReadRequest) begin
        got = 1'b1;
        k = c;
      end
    end
    check("issue_latency", k, 1);
    if (!got) return;
    strobes = 0;
    if (stray_issue) begin
      #1 SDRAM_DataReady = 1'b1;
    end
    for (int b = 0; b < BW; b++) begin
      @(posedge clk); #1;
      SDRAM_DataReady = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      if (abort_after != 0 && b == abort_after) begin
        reset = 1'b0;
        SDRAM_DataIn = $urandom;
        SDRAM_DataReady = 1'b1;
        @(negedge clk);
        check("rst_sdram_req", SDRAM_ReadRequest, 0);
        check("rst_i_ready", I_DataReady, 0);
        check("rst_d_ready", D_DataReady, 0);
        check("rst_busy", Busy, 0);
        check("rst_grant", GrantD, 0);
        check("rst_addr", SDRAM_ReadAddress, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        fav_d = 1'b0;
        I_ReadRequest = 1'b0;
        D_ReadRequest = 1'b0;
        for (int r = 0; r < 2; r++) begin
          SDRAM_DataIn = $urandom;
          SDRAM_DataReady = 1'b1;
          @(posedge clk); #1;
        end
        SDRAM_DataReady = 1'b0;
        @(negedge clk);
        check("abort_strobes", strobes, abort_after);
        check("abort_busy", Busy, 0);
        return;
      end
      data = $urandom;
      SDRAM_DataIn = data;
      SDRAM_DataReady = 1'b1;
      beat_q.push_back('{d: w, v: data});
    end
    @(posedge clk); #1;
    SDRAM_DataReady = 1'b0;
    if (!hold) drop(w);
    @(negedge clk);
    check("beat_count", strobes, BW);
    check("busy_after_burst", Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    I_ReadRequest = 1'b0;
    D_ReadRequest = 1'b0;
    I_ReadAddress = '0;
    D_ReadAddress = '0;
    SDRAM_DataIn = '0;
    SDRAM_DataReady = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", Busy, 0);
    check("reset_sdram_req", SDRAM_ReadRequest, 0);
    check("reset_grant", GrantD, 0);
    check("reset_addr", SDRAM_ReadAddress, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single icache miss.
    I_ReadAddress = 32'h0000_1234;
    raise(1, 0);
    run_burst(0, 0, 0);

    // Stray beat in IDLE, then a dcache burst with a stray beat during ISSUE.
    @(posedge clk); #1;
    SDRAM_DataReady = 1'b1;
    @(posedge clk); #1;
    SDRAM_DataReady = 1'b0;
    @(negedge clk);
    check("stray_busy", Busy, 0);
    D_ReadAddress = 32'h0000_5678;
    raise(0, 1);
    run_burst(0, 1, 0);

    // Reset after beat 2 of 4, then a normal dcache request.
    I_ReadAddress = 32'h0000_4004;
    raise(1, 0);
    run_burst(0, 0, 2);
    D_ReadAddress = 32'h0000_2ABC;
    raise(0, 1);
    run_burst(0, 0, 0);

    // Ties after a fresh reset.
    @(posedge clk); #1;
    reset = 1'b0;
    fav_d = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    I_ReadAddress = 32'h0000_0100;
    D_ReadAddress = 32'h0000_0200;
    raise(1, 1);
    run_burst(0, 0, 0);
    run_burst(0, 0, 0);
    raise(1, 1);
    run_burst(1, 0, 0);
    run_burst(0, 0, 0);
    run_burst(0, 0, 0);

    // Back-to-back from the icache with the request held through u+1.
    I_ReadAddress = 32'h0000_3334;
    raise(1, 0);
    run_burst(1, 0, 0);
    run_burst(0, 0, 0);

    repeat (3) @(negedge clk);
    check("req_queue_empty", req_q.size(), 0);
    check("beat_queue_empty", beat_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
